// File: rtl/cdb_broadcast_unit.sv
// Common Data Bus writer: per-source result FIFOs, round-robin arbitration and a
// registered single-result-per-cycle broadcast to the register status table and stations.
module cdb_broadcast_unit #(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       TAG_W     = 4,
  parameter int unsigned       DEPTH     = 2,
  parameter logic [DATA_W-1:0] IDLE_DATA = 16'hFFF0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Flush,
  input  logic [2:0]            Req_Valid,
  input  logic [3*TAG_W-1:0]    Req_Tag,
  input  logic [3*DATA_W-1:0]   Req_Data,
  output logic [2:0]            Req_Ready,
  output logic                  CDB_Valid,
  output logic [TAG_W-1:0]      CDB_Tag,
  output logic [DATA_W-1:0]     CDB_Data,
  output logic [1:0]            CDB_Src
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LastPtr = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  logic [TAG_W-1:0]  r_tag    [3][DEPTH];
  logic [DATA_W-1:0] r_data   [3][DEPTH];
  logic [PW-1:0]     r_rd_ptr [3];
  logic [PW-1:0]     r_wr_ptr [3];
  logic [CW-1:0]     r_count  [3];
  logic [1:0]        r_rr;

  logic              r_cdb_valid;
  logic [TAG_W-1:0]  r_cdb_tag;
  logic [DATA_W-1:0] r_cdb_data;
  logic [1:0]        r_cdb_src;

  logic [2:0]        w_cand;
  logic [2:0]        w_push;
  logic [2:0]        w_store;
  logic [2:0]        w_pop;
  logic [1:0]        w_order [3];
  logic              w_grant;
  logic [1:0]        w_gidx;
  logic [TAG_W-1:0]  w_sel_tag;
  logic [DATA_W-1:0] w_sel_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [1:0] mod3_inc(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Ready is taken from registered counts only, so a same-edge pop never frees a slot early.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      Req_Ready[i] = (r_count[i] < FullCnt);
      w_cand[i]    = (r_count[i] != '0);
      w_push[i]    = Req_Valid[i] & Req_Ready[i];
      w_store[i]   = w_push[i] & (Req_Tag[i*TAG_W +: TAG_W] != '0);
    end
  end

  always_comb begin
    w_order[0] = r_rr;
    w_order[1] = mod3_inc(r_rr);
    w_order[2] = mod3_inc(w_order[1]);
    w_grant    = 1'b0;
    w_gidx     = 2'd0;
    // Scan lowest priority first so the highest-priority candidate overwrites.
    for (int k = 2; k >= 0; k--) begin
      if (w_cand[w_order[k]]) begin
        w_grant = 1'b1;
        w_gidx  = w_order[k];
      end
    end
  end

  always_comb begin
    w_pop      = '0;
    w_sel_tag  = '0;
    w_sel_data = '0;
    for (int i = 0; i < 3; i++) begin
      if (w_grant && (w_gidx == 2'(i))) begin
        w_pop[i]   = 1'b1;
        w_sel_tag  = r_tag[i][r_rd_ptr[i]];
        w_sel_data = r_data[i][r_rd_ptr[i]];
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 3; i++) begin
        r_rd_ptr[i] <= '0;
        r_wr_ptr[i] <= '0;
        r_count[i]  <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          r_tag[i][j]  <= '0;
          r_data[i][j] <= '0;
        end
      end
      r_rr        <= 2'd0;
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= IDLE_DATA;
      r_cdb_src   <= 2'd0;
    end else if (Flush) begin
      for (int i = 0; i < 3; i++) begin
        r_rd_ptr[i] <= '0;
        r_wr_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
      r_rr        <= 2'd0;
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= IDLE_DATA;
      r_cdb_src   <= 2'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_store[i]) begin
          r_tag[i][r_wr_ptr[i]]  <= Req_Tag[i*TAG_W +: TAG_W];
          r_data[i][r_wr_ptr[i]] <= Req_Data[i*DATA_W +: DATA_W];
          r_wr_ptr[i]            <= ptr_inc(r_wr_ptr[i]);
        end
        if (w_pop[i]) begin
          r_rd_ptr[i] <= ptr_inc(r_rd_ptr[i]);
        end
        if (w_store[i] && !w_pop[i]) begin
          r_count[i] <= r_count[i] + 1'b1;
        end else if (!w_store[i] && w_pop[i]) begin
          r_count[i] <= r_count[i] - 1'b1;
        end
      end
      if (w_grant) begin
        r_cdb_valid <= 1'b1;
        r_cdb_tag   <= w_sel_tag;
        r_cdb_data  <= w_sel_data;
        r_cdb_src   <= w_gidx;
        r_rr        <= mod3_inc(w_gidx);
      end else begin
        r_cdb_valid <= 1'b0;
        r_cdb_tag   <= '0;
        r_cdb_data  <= IDLE_DATA;
        r_cdb_src   <= 2'd0;
      end
    end
  end

  assign CDB_Valid = r_cdb_valid;
  assign CDB_Tag   = r_cdb_tag;
  assign CDB_Data  = r_cdb_data;
  assign CDB_Src   = r_cdb_src;

endmodule

// File: tb/tb_cdb_broadcast_unit.sv
// Directed bench for cdb_broadcast_unit: latency, round-robin, backpressure, tag-0 drop,
// flush and asynchronous reset, with hand-computed expected output words.
module tb_cdb_broadcast_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Flush;
  logic [2:0]  Req_Valid;
  logic [11:0] Req_Tag;
  logic [47:0] Req_Data;
  logic [2:0]  Req_Ready;
  logic        CDB_Valid;
  logic [3:0]  CDB_Tag;
  logic [15:0] CDB_Data;
  logic [1:0]  CDB_Src;

  int n_vec = 0;
  int n_err = 0;

  // {valid, tag, data, src, ready}
  logic [25:0] obs;
  assign obs = {CDB_Valid, CDB_Tag, CDB_Data, CDB_Src, Req_Ready};

  cdb_broadcast_unit #(
    .DATA_W    (16),
    .TAG_W     (4),
    .DEPTH     (2),
    .IDLE_DATA (16'hFFF0)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Flush     (Flush),
    .Req_Valid (Req_Valid),
    .Req_Tag   (Req_Tag),
    .Req_Data  (Req_Data),
    .Req_Ready (Req_Ready),
    .CDB_Valid (CDB_Valid),
    .CDB_Tag   (CDB_Tag),
    .CDB_Data  (CDB_Data),
    .CDB_Src   (CDB_Src)
  );

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Flush     = 1'b0;
    Req_Valid = 3'b000;
    Req_Tag   = '0;
    Req_Data  = '0;
    Reset     = 1'b1;
    step();
    Reset     = 1'b0;
  endtask

  task automatic test_reset();
    Flush     = 1'b0;
    Req_Valid = 3'b000;
    Req_Tag   = '0;
    Req_Data  = '0;
    Reset     = 1'b0;
    #1 Reset  = 1'b1;
    #1;
    n_vec++;
    if (obs !== {1'b0, 4'd0, 16'hFFF0, 2'd0, 3'b111}) begin
      n_err++;
      $display("FAIL reset_async got %h want %h", obs, {1'b0, 4'd0, 16'hFFF0, 2'd0, 3'b111});
    end
    step();
    Reset = 1'b0;
    step();
    n_vec++;
    if (obs !== {1'b0, 4'd0, 16'hFFF0, 2'd0, 3'b111}) begin
      n_err++;
      $display("FAIL reset_release got %h want %h", obs, {1'b0, 4'd0, 16'hFFF0, 2'd0, 3'b111});
    end
  endtask

  task automatic test_latency();
    logic [25:0] exp_v [0:3];
    exp_v[0] = {1'b0, 4'd0, 16'hFFF0, 2'd0, 3'b111};
    exp_v[1] = {1'b0, 4'd0, 16'hFFF0, 2'd0, 3'b111};
    exp_v[2] = {1'b1, 4'd1, 16'h0005, 2'd0, 3'b111};
    exp_v[3] = {1'b0, 4'd0, 16'hFFF0, 2'd0, 3'b111};
    do_reset();
    Req_Valid = 3'b001;
    Req_Tag   = {4'd0, 4'd0, 4'd1};
    Req_Data  = {16'h0, 16'h0, 16'h0005};
    for (int e = 0; e <= 3; e++) begin
      if (e > 0) step();
      if (e == 1) Req_Valid = 3'b000;
      n_vec++;
      if (obs !== exp_v[e]) begin
        n_err++;
        $display("FAIL latency_e%0d got %h want %h", e, obs, exp_v[e]);
      end
    end
  endtask

  task automatic test_all_push();
    logic [25:0] exp_v [1:5];
    exp_v[1] = {1'b0, 4'd0, 16'hFFF0, 2'd0, 3'b111};
    exp_v[2] = {1'b1, 4'd1, 16'h0011, 2'd0, 3'b111};
    exp_v[3] = {1'b1, 4'd2, 16'h0022, 2'd1, 3'b111};
    exp_v[4] = {1'b1, 4'd3, 16'h0033, 2'd2, 3'b111};
    exp_v[5] = {1'b0, 4'd0, 16'hFFF0, 2'd0, 3'b111};
    do_reset();
    Req_Valid = 3'b111;
    Req_Tag   = {4'd3, 4'd2, 4'd1};
    Req_Data  = {16'h0033, 16'h0022, 16'h0011};
    for (int e = 1; e <= 5; e++) begin
      step();
      Req_Valid = 3'b000;
      n_vec++;
      if (obs !== exp_v[e]) begin
        n_err++;
        $display("FAIL all_push_e%0d got %h want %h", e, obs, exp_v[e]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [25:0] exp_v [1:9];
    exp_v[1] = {1'b0, 4'd0, 16'hFFF0, 2'd0, 3'b111};
    exp_v[2] = {1'b1, 4'd1, 16'h0101, 2'd0, 3'b001};
    exp_v[3] = {1'b1, 4'd2, 16'h000A, 2'd1, 3'b011};
    exp_v[4] = {1'b1, 4'd3, 16'h0301, 2'd2, 3'b101};
    exp_v[5] = {1'b1, 4'd1, 16'h0102, 2'd0, 3'b101};
    exp_v[6] = {1'b1, 4'd2, 16'h000B, 2'd1, 3'b111};
    exp_v[7] = {1'b1, 4'd3, 16'h0302, 2'd2, 3'b111};
    exp_v[8] = {1'b1, 4'd2, 16'h000C, 2'd1, 3'b111};
    exp_v[9] = {1'b0, 4'd0, 16'hFFF0, 2'd0, 3'b111};
    do_reset();
    for (int e = 1; e <= 9; e++) begin
      case (e)
        1: begin
          Req_Valid = 3'b111;
          Req_Tag   = {4'd3, 4'd2, 4'd1};
          Req_Data  = {16'h0301, 16'h000A, 16'h0101};
        end
        2: begin
          Req_Valid = 3'b111;
          Req_Tag   = {4'd3, 4'd2, 4'd1};
          Req_Data  = {16'h0302, 16'h000B, 16'h0102};
        end
        3, 4: begin
          // C is held on source 1 until its buffer frees an entry.
          Req_Valid = 3'b010;
          Req_Tag   = {4'd0, 4'd2, 4'd0};
          Req_Data  = {16'h0, 16'h000C, 16'h0};
        end
        default: Req_Valid = 3'b000;
      endcase
      step();
      n_vec++;
      if (obs !== exp_v[e]) begin
        n_err++;
        $display("FAIL back_to_back_e%0d got %h want %h", e, obs, exp_v[e]);
      end
    end
    Req_Valid = 3'b000;
  endtask

  task automatic test_tag_zero();
    do_reset();
    Req_Valid = 3'b100;
    Req_Tag   = {4'd0, 4'd0, 4'd0};
    Req_Data  = {16'h0BAD, 16'h0, 16'h0};
    n_vec++;
    if (Req_Ready[2] !== 1'b1) begin
      n_err++;
      $display("FAIL tag_zero_ready got %b want 1", Req_Ready[2]);
    end
    for (int e = 1; e <= 3; e++) begin
      step();
      Req_Valid = 3'b000;
      n_vec++;
      if (obs !== {1'b0, 4'd0, 16'hFFF0, 2'd0, 3'b111}) begin
        n_err++;
        $display("FAIL tag_zero_e%0d got %h want %h", e, obs,
                 {1'b0, 4'd0, 16'hFFF0, 2'd0, 3'b111});
      end
    end
  endtask

  task automatic test_flush();
    logic [25:0] exp_v [3:9];
    exp_v[3] = {1'b0, 4'd0, 16'hFFF0, 2'd0, 3'b111};
    exp_v[4] = {1'b0, 4'd0, 16'hFFF0, 2'd0, 3'b111};
    exp_v[5] = {1'b0, 4'd0, 16'hFFF0, 2'd0, 3'b111};
    exp_v[6] = {1'b0, 4'd0, 16'hFFF0, 2'd0, 3'b111};
    exp_v[7] = {1'b1, 4'd5, 16'h0055, 2'd0, 3'b111};
    exp_v[8] = {1'b1, 4'd6, 16'h0066, 2'd1, 3'b111};
    exp_v[9] = {1'b1, 4'd7, 16'h0077, 2'd2, 3'b111};
    do_reset();
    Req_Valid = 3'b111;
    Req_Tag   = {4'd3, 4'd2, 4'd1};
    Req_Data  = {16'h0031, 16'h0021, 16'h0011};
    step();
    Req_Data  = {16'h0032, 16'h0022, 16'h0012};
    step();
    Flush     = 1'b1;
    Req_Valid = 3'b001;
    Req_Tag   = {4'd0, 4'd0, 4'd1};
    Req_Data  = {16'h0, 16'h0, 16'h0EEE};
    n_vec++;
    if (obs !== {1'b1, 4'd1, 16'h0011, 2'd0, 3'b001}) begin
      n_err++;
      $display("FAIL flush_pre got %h want %h", obs, {1'b1, 4'd1, 16'h0011, 2'd0, 3'b001});
    end
    for (int e = 3; e <= 9; e++) begin
      if (e == 6) begin
        Req_Valid = 3'b111;
        Req_Tag   = {4'd7, 4'd6, 4'd5};
        Req_Data  = {16'h0077, 16'h0066, 16'h0055};
      end
      step();
      Flush     = 1'b0;
      Req_Valid = 3'b000;
      n_vec++;
      if (obs !== exp_v[e]) begin
        n_err++;
        $display("FAIL flush_e%0d got %h want %h", e, obs, exp_v[e]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    Req_Valid = 3'b010;
    Req_Tag   = {4'd0, 4'd2, 4'd0};
    Req_Data  = {16'h0, 16'h0BEE, 16'h0};
    step();
    Req_Data  = {16'h0, 16'h0BEF, 16'h0};
    step();
    Req_Valid = 3'b000;
    n_vec++;
    if (obs !== {1'b1, 4'd2, 16'h0BEE, 2'd1, 3'b111}) begin
      n_err++;
      $display("FAIL areset_pre got %h want %h", obs, {1'b1, 4'd2, 16'h0BEE, 2'd1, 3'b111});
    end
    #2 Reset = 1'b1;
    #1;
    n_vec++;
    if (obs !== {1'b0, 4'd0, 16'hFFF0, 2'd0, 3'b111}) begin
      n_err++;
      $display("FAIL areset_now got %h want %h", obs, {1'b0, 4'd0, 16'hFFF0, 2'd0, 3'b111});
    end
    #1 Reset = 1'b0;
    for (int e = 1; e <= 2; e++) begin
      step();
      n_vec++;
      if (obs !== {1'b0, 4'd0, 16'hFFF0, 2'd0, 3'b111}) begin
        n_err++;
        $display("FAIL areset_after_e%0d got %h want %h", e, obs,
                 {1'b0, 4'd0, 16'hFFF0, 2'd0, 3'b111});
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_all_push();
    test_back_to_back();
    test_tag_zero();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cdb_broadcast_unit.md
# cdb_broadcast_unit

Common Data Bus (CDB) writer for the Tomasulo core. It collects completed results (tag + value) from the functional units behind the reservation stations. Each source gets a small per-source buffer, and the unit arbitrates between sources round-robin. It broadcasts at most one result per cycle to `register_status` and to the reservation stations, which are the receivers of `Qi_CDB`/`Qi_CDB_data`.

## Interface
Parameters:
- `DATA_W`, 16: result width.
- `TAG_W`, 4: tag width. Tag 0 means "no station".
- `DEPTH`, 2: entries per source buffer. Legal values are 1..4.
- `IDLE_DATA`, 16'hFFF0: value driven on `CDB_Data` when there is no broadcast.

Ports:
- `Clock`, in, 1: rising-edge clock.
- `Reset`, in, 1: asynchronous reset, active-high.
- `Flush`, in, 1: synchronous clear of all buffered results.
- `Req_Valid`, in, 3: per-source result valid. Source 0 is ADD1, 1 is ADD2, 2 is spare FU.
- `Req_Tag`, in, 3×`TAG_W`: source i occupies bits [i*TAG_W +: TAG_W]. This is the producing station's tag.
- `Req_Data`, in, 3×`DATA_W`: source i occupies bits [i*DATA_W +: DATA_W].
- `Req_Ready`, out, 3: source i buffer can accept.
- `CDB_Valid`, out, 1: a broadcast is present this cycle.
- `CDB_Tag`, out, `TAG_W`: broadcast tag. Connects to `Qi_CDB`.
- `CDB_Data`, out, `DATA_W`: broadcast value. Connects to `Qi_CDB_data`.
- `CDB_Src`, out, 2: index of the source being broadcast. Used for debug and verification.

## Operation
Per-source buffer:
- Each source has its own FIFO of `DEPTH` entries, storing {tag, data}, with a read pointer, a write pointer and a count.
- `Req_Ready[i]` is `count_i < DEPTH`. It depends only on registered state; there is no combinational path from pop.
- A push happens on a rising edge when `Req_Valid[i] & Req_Ready[i]`.
- A request with `Req_Tag` == 0 is handshaken (consumed) but not stored.
- Pointers wrap modulo `DEPTH`.

Arbitration:
- Register `rr` holds the highest-priority source and takes values 0..2.
- Each cycle the candidates are the sources with `count_i > 0`. The winner is the first candidate found scanning rr, rr+1, rr+2 (mod 3).
- On a grant to source i, the head entry of source i is popped and loaded into the CDB output registers, and `rr` becomes (i+1) mod 3.
- If there are no candidates, `CDB_Valid` goes to 0 and `rr` is unchanged.

CDB outputs:
- All CDB outputs are registered.
- When `CDB_Valid` = 1, `CDB_Tag`, `CDB_Data` and `CDB_Src` hold the granted entry for exactly one cycle.
- When `CDB_Valid` = 0, `CDB_Tag` = 0, `CDB_Data` = `IDLE_DATA` and `CDB_Src` = 0.

Simultaneous events:
- Push and pop on the same source in the same edge leave `count` unchanged and the data stays ordered. This is legal only while `count < DEPTH`, because ready is taken pre-pop.
- Pushes to all three sources in one edge are all accepted if ready.
- The FIFO is strictly in order within a source. There is no ordering guarantee across sources beyond the round-robin rule.

Flush:
- On the edge where `Flush` = 1, all counts and pointers clear, `CDB_Valid` goes to 0 and `rr` goes to 0.
- Pushes in that cycle are discarded; `Req_Ready` still shows its pre-flush value.
- `Flush` has priority over push and pop.

Reset:
- Asynchronous and immediate.
- `Req_Ready` = 3'b111, `CDB_Valid` = 0, `CDB_Tag` = 0, `CDB_Data` = `IDLE_DATA`, `CDB_Src` = 0, `rr` = 0, all counts = 0.
- Reset mid-broadcast drops the current broadcast and all buffered entries. No partial output is allowed.

## Timing
- Latency: an entry pushed at edge k into an empty unit appears on the CDB after edge k+1 and is held until edge k+2. The entry is not bypassed at edge k.
- Throughput: one broadcast per cycle, sustained while any buffer is non-empty.
- Fairness: with all three sources continuously backlogged, grants follow the period 0,1,2,0,1,2… starting from `rr`. No source waits more than 2 cycles once it is at the head of its buffer.
- `Req_Ready[i]` deasserts in the cycle after the push that fills the buffer. It reasserts in the cycle after the pop that frees an entry.
- Receivers sample the CDB outputs on the edge at which `CDB_Valid` is high. The unit never holds a broadcast for more than one cycle.

## Test plan
1. Reset, then source 0 pushes tag 1, data 16'h0005 at edge 1. Required: `CDB_Valid` = 1, `CDB_Tag` = 1, `CDB_Data` = 16'h0005, `CDB_Src` = 0 after edge 2 only. Otherwise `CDB_Data` = 16'hFFF0 and `CDB_Tag` = 0.
2. All sources push in the same edge: tags 1, 2, 3, data 16'h0011, 16'h0022, 16'h0033, with `rr` = 0. Required: three consecutive broadcasts with tags 1, 2, 3 and `Req_Ready` = 3'b111 throughout.
3. Source 1 pushes 3 back-to-back entries with tags 2, 2, 2 and data 16'h000A, 16'h000B, 16'h000C while sources 0 and 2 hold their buffers full, with `DEPTH` = 2. Required: `Req_Ready[1]` drops after the second push, and the third push is stalled until a pop. Source 1's data emerges in order A, B, C, interleaved round-robin with the other sources.
4. Source 2 pushes with `Req_Tag` = 0. Required: the push is handshaken, nothing is broadcast, and `CDB_Valid` stays 0.
5. Fill all buffers, then assert `Flush` for one cycle together with a push from source 0. Required: `CDB_Valid` = 0 from the next cycle, all `Req_Ready` = 1, no stale tag is ever broadcast, and `rr` = 0, so the next grant goes to source 0.
6. Assert `Reset` asynchronously mid-cycle while `CDB_Valid` = 1 with tag 2. Required: outputs return to their reset values immediately, before the next edge, and the buffers are empty after release.
